lfsr_rng: RTL and testbench
===========================

# lfsr_rng

Parametrised pseudo-random source for game logic such as obstacle spawn timing and obstacle type selection. It wraps a seedable XNOR Fibonacci LFSR, 3 to 16 bits wide, in a request/done draw engine. The engine returns a value uniformly drawn in `[0, limit)` by rejection sampling, with a bounded retry count. It replaces fixed-seed free-running LFSR instances: it adds seed load, lock-up protection, and bounded-range draws.

## Interface
Parameters:
- `WIDTH`, 16: LFSR length in bits; legal range 3..16.
- `OUT_BITS`, 4: draw width; legal range 1..WIDTH.
- `SEED`, alternating `...0101` pattern of WIDTH bits: reset and substitute seed.
- `MAX_TRIES`, 8: candidate evaluations per draw before fallback; legal range 1..255.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `free_run`  in  1: step the LFSR every cycle while IDLE.
- `seed_load`  in  1: load `seed_value` into the LFSR.
- `seed_value`  in  WIDTH: seed to load.
- `req`  in  1: draw request; accepted only when `busy`=0.
- `limit`  in  OUT_BITS: exclusive upper bound; 0 means full range. Sampled at acceptance.
- `busy`  out  1: high while in DRAW.
- `done`  out  1: one-cycle pulse when a draw completes.
- `value`  out  OUT_BITS: drawn value; held until the next `done`.
- `fallback`  out  1: set with `done` when retries were exhausted; held with `value`.
- `lfsr_state`  out  WIDTH: current LFSR register.

## Operation
- **Step rule:** `next = {state[WIDTH-2:0], fb}`. `fb` is the XNOR of the XAPP052 taps for WIDTH, bit k of the polynomial being `state[k-1]`.
  - Taps for WIDTH=8 are 8, 6, 5, 4.
  - The all-ones state is the lock-up state.
- **Seed load:** if `seed_value` is all-ones, load `SEED` instead. The LFSR never holds all-ones.
- **Priority each edge:** `rst` > `seed_load` > step.
  - Step occurs when in DRAW, or when in IDLE with `free_run`=1.
- **FSM states:**
  - IDLE: when `req`=1, go to DRAW; latch `limit` to `lim_q` and clear the try counter.
  - DRAW: candidate `c` = `state[OUT_BITS-1:0]`, taken from the current register before this cycle's step. The LFSR steps at the same edge. The try counter increments per candidate.
    - If `lim_q`=0 or `c` < `lim_q`: accept, go to IDLE, register `value`=`c`, `fallback`=0, `done`=1.
    - Else, if this was candidate number MAX_TRIES: go to IDLE, register `value`=0, `fallback`=1, `done`=1.
    - Otherwise stay in DRAW.
- **`seed_load` in DRAW:** aborts the draw and goes to IDLE. No `done` pulse; `value` and `fallback` keep their previous contents.
- **`req` while busy:** ignored, not queued.
- **`req` during the `done` cycle:** accepted, because the FSM is already in IDLE.
- **Arithmetic:** the comparison is unsigned on OUT_BITS. The try counter is 8 bits wide and saturates.

## Timing
- **Reset values:** `lfsr_state`=SEED, `busy`=0, `done`=0, `value`=0, `fallback`=0, FSM in IDLE.
- **Latency:** with `req` high in cycle t, `busy`=1 from t+1. The earliest `done` is at t+2. The worst case is `done` at t+1+MAX_TRIES.
- **`done` pulse:** exactly one cycle; `busy` is 0 in that cycle.
- **LFSR advance per draw:** exactly one step per candidate evaluated.

## Structure
- Package `lfsr_pkg`:
  - function `lfsr_taps(width)` returning a 16-bit tap mask.
  - localparams for the legal WIDTH range and the FSM state encoding.
- Sub-module `lfsr_core` holds the stepping register, the load, and the lock-up substitution. Its ports are `clk`, `rst`, `step`, `load`, `load_value`, `state`.
- `lfsr_rng` holds the FSM, the try counter, `lim_q` and the output registers.

## Test plan
All scenarios use WIDTH=8, OUT_BITS=4, SEED=0x55, MAX_TRIES=2 unless stated.
- **Reset / free run:** after `rst`, `lfsr_state`=0x55. Assert `free_run` for 3 cycles -> `lfsr_state` reads 0xAA, 0x54, 0xA8.
- **Full-range draw:** from reset, `req` for 1 cycle with `limit`=0 -> `done` 2 cycles later, `value`=5, `fallback`=0, `lfsr_state`=0xAA.
- **Fallback:** then `req` with `limit`=3 -> candidates 0xA and 0x4 are rejected. `done` follows 3 cycles after `req`, with `value`=0, `fallback`=1 and `lfsr_state`=0xA8.
- **Lock-up guard and accept after rejections:** `seed_load` with `seed_value`=0xFF -> `lfsr_state`=0x55. Then, with MAX_TRIES=8, `req` with `limit`=6 -> candidate 5 is accepted on the first try.
- **Abort:** `seed_load`=1 with `seed_value`=0x33 in the first DRAW cycle -> next cycle IDLE, `lfsr_state`=0x33, no `done` pulse, `value` unchanged.
- **Back-to-back:** `req` held high continuously -> `done` every 2 cycles with `limit`=0. `req` asserted while `busy` is high has no effect.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants, FSM encoding and tap table for the lfsr_rng draw engine.
package lfsr_pkg;

  // Supported LFSR lengths.
  localparam int unsigned LFSR_MIN_WIDTH = 3;
  localparam int unsigned LFSR_MAX_WIDTH = 16;

  // Draw engine FSM encoding.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DRAW = 1'b1
  } rng_state_e;

  // XAPP052 maximal-length taps; bit k-1 of the mask is tap k.
  function automatic logic [15:0] lfsr_taps(input int unsigned width);
    logic [15:0] mask;
    mask = 16'h0000;
    case (width)
      3:  mask = 16'h0006; // 3,2
      4:  mask = 16'h000C; // 4,3
      5:  mask = 16'h0014; // 5,3
      6:  mask = 16'h0030; // 6,5
      7:  mask = 16'h0060; // 7,6
      8:  mask = 16'h00B8; // 8,6,5,4
      9:  mask = 16'h0110; // 9,5
      10: mask = 16'h0240; // 10,7
      11: mask = 16'h0500; // 11,9
      12: mask = 16'h0829; // 12,6,4,1
      13: mask = 16'h100D; // 13,4,3,1
      14: mask = 16'h2015; // 14,5,3,1
      15: mask = 16'h6000; // 15,14
      16: mask = 16'hD008; // 16,15,13,4
      default: mask = 16'h0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Seedable XNOR Fibonacci LFSR. Never holds the all-ones lock-up state:
// an all-ones load value is replaced by SEED. Priority: rst > load > step.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'h5555)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] TAP_MASK = WIDTH'(lfsr_taps(WIDTH));

  logic             fb;
  logic [WIDTH-1:0] load_safe;

  // XNOR feedback keeps all-zeros legal and makes all-ones the lock-up state.
  assign fb        = ~^(state & TAP_MASK);
  assign load_safe = (&load_value) ? SEED : load_value;

  // LFSR register: reset, seed load, or one shift step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= load_safe;
    end else if (step) begin
      state <= {state[WIDTH-2:0], fb};
    end
  end

endmodule

// File: rtl/lfsr_rng.sv
// Bounded-range random draw engine around lfsr_core. Draws a value in
// [0, limit) by rejection sampling, giving up after MAX_TRIES candidates.
//
// Handshake: req is accepted on any edge where busy=0 (FSM in IDLE); limit is
// captured at that edge. busy is high for the whole DRAW phase and mirrors the
// FSM state. done is a one-cycle pulse in the first IDLE cycle after the draw;
// value/fallback are valid with done and held until the next done. A req seen
// while busy is dropped, not queued. seed_load during DRAW aborts silently.
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      OUT_BITS  = 4,
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(16'h5555),
  parameter int unsigned      MAX_TRIES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                free_run,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed_value,
  input  logic                req,
  input  logic [OUT_BITS-1:0] limit,
  output logic                busy,
  output logic                done,
  output logic [OUT_BITS-1:0] value,
  output logic                fallback,
  output logic [WIDTH-1:0]    lfsr_state
);

  localparam logic [7:0] MAX_T = 8'(MAX_TRIES);

  rng_state_e          state_q, state_d;
  logic [OUT_BITS-1:0] lim_q;
  logic [7:0]          tries_q;
  logic [7:0]          tries_inc;
  logic [OUT_BITS-1:0] cand;
  logic                accept;
  logic                last_try;
  logic                step;
  logic                finish_ok;
  logic                finish_fb;

  // Candidate comes from the register before this edge's step.
  assign cand      = lfsr_state[OUT_BITS-1:0];
  assign accept    = (lim_q == '0) || (cand < lim_q);
  assign tries_inc = (tries_q == 8'hFF) ? 8'hFF : tries_q + 8'd1;
  assign last_try  = (tries_inc >= MAX_T);
  assign busy      = (state_q == ST_DRAW);
  assign step      = (state_q == ST_DRAW) || free_run;

  lfsr_core #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .step       (step),
    .load       (seed_load),
    .load_value (seed_value),
    .state      (lfsr_state)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and draw completion decode.
  always_comb begin
    state_d   = state_q;
    finish_ok = 1'b0;
    finish_fb = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) state_d = ST_DRAW;
      end
      ST_DRAW: begin
        if (seed_load) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          state_d   = ST_IDLE;
          finish_ok = 1'b1;
        end else if (last_try) begin
          state_d   = ST_IDLE;
          finish_fb = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture, try counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lim_q    <= '0;
      tries_q  <= 8'd0;
      done     <= 1'b0;
      value    <= '0;
      fallback <= 1'b0;
    end else begin
      done <= finish_ok | finish_fb;
      if (state_q == ST_IDLE && req) begin
        lim_q   <= limit;
        tries_q <= 8'd0;
      end else if (state_q == ST_DRAW) begin
        tries_q <= tries_inc;
      end
      if (finish_ok) begin
        value    <= cand;
        fallback <= 1'b0;
      end else if (finish_fb) begin
        value    <= '0;
        fallback <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_rng.sv
// Bench for lfsr_rng: two instances (MAX_TRIES=2 and 8) share stimulus; an
// independent LFSR/draw model fills per-instance expected queues.
module tb_lfsr_rng;

  localparam int W = 13; // {fallback, value[3:0], lfsr_state[7:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, free_run, seed_load, req;
  logic [7:0] seed_value;
  logic [3:0] limit;

  logic       busy_a, done_a, fallback_a;
  logic [3:0] value_a;
  logic [7:0] lfsr_a;
  logic       busy_b, done_b, fallback_b;
  logic [3:0] value_b;
  logic [7:0] lfsr_b;

  lfsr_rng #(.WIDTH(8), .OUT_BITS(4), .SEED(8'h55), .MAX_TRIES(2)) dut_a (
    .clk(clk), .rst(rst), .free_run(free_run), .seed_load(seed_load),
    .seed_value(seed_value), .req(req), .limit(limit), .busy(busy_a),
    .done(done_a), .value(value_a), .fallback(fallback_a), .lfsr_state(lfsr_a)
  );

  lfsr_rng #(.WIDTH(8), .OUT_BITS(4), .SEED(8'h55), .MAX_TRIES(8)) dut_b (
    .clk(clk), .rst(rst), .free_run(free_run), .seed_load(seed_load),
    .seed_value(seed_value), .req(req), .limit(limit), .busy(busy_b),
    .done(done_b), .value(value_b), .fallback(fallback_b), .lfsr_state(lfsr_b)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [W-1:0] exp_qa[$];
  logic [W-1:0] exp_qb[$];
  logic [W-1:0] e_a, e_b;
  logic [7:0] ms_a, ms_b;   // model LFSR state per instance
  logic [3:0] last_va;      // model of value_a currently held

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] step8(input logic [7:0] s);
    return {s[6:0], ~(s[7] ^ s[5] ^ s[4] ^ s[3])};
  endfunction

  task automatic draw_model(input logic [7:0] s0, input logic [3:0] lim, input int mt,
                            output logic [7:0] s_end, output logic [3:0] v,
                            output logic fbk, output int lat);
    logic [7:0] s;
    logic [3:0] c;
    s   = s0;
    v   = 4'd0;
    fbk = 1'b1;
    lat = mt + 1;
    for (int t = 1; t <= mt; t++) begin
      c = s[3:0];
      s = step8(s);
      if (lim == 4'd0 || c < lim) begin
        v   = c;
        fbk = 1'b0;
        lat = t + 1;
        break;
      end
    end
    s_end = s;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (done_a) begin
      chk("a_busy_at_done", 32'(busy_a), 32'(0));
      if (exp_qa.size() == 0) begin
        chk("a_unexpected_done", 32'(done_a), 32'(0));
      end else begin
        e_a = exp_qa.pop_front();
        chk("a_value", 32'(value_a), 32'(e_a[11:8]));
        chk("a_fallback", 32'(fallback_a), 32'(e_a[12]));
        chk("a_state", 32'(lfsr_a), 32'(e_a[7:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (done_b) begin
      chk("b_busy_at_done", 32'(busy_b), 32'(0));
      if (exp_qb.size() == 0) begin
        chk("b_unexpected_done", 32'(done_b), 32'(0));
      end else begin
        e_b = exp_qb.pop_front();
        chk("b_value", 32'(value_b), 32'(e_b[11:8]));
        chk("b_fallback", 32'(fallback_b), 32'(e_b[12]));
        chk("b_state", 32'(lfsr_b), 32'(e_b[7:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ms_a    = 8'h55;
    ms_b    = 8'h55;
    last_va = 4'd0;
  endtask

  task automatic do_draw(input logic [3:0] lim);
    logic [7:0] sa, sb;
    logic [3:0] va, vb;
    logic       fa, fb;
    int         la_exp, lb_exp, la, lb;
    draw_model(ms_a, lim, 2, sa, va, fa, la_exp);
    draw_model(ms_b, lim, 8, sb, vb, fb, lb_exp);
    exp_qa.push_back({fa, va, sa});
    exp_qb.push_back({fb, vb, sb});
    ms_a    = sa;
    ms_b    = sb;
    last_va = va;
    @(posedge clk); #1;
    req   = 1'b1;
    limit = lim;
    la = 0;
    lb = 0;
    for (int i = 1; i <= 16 && (la == 0 || lb == 0); i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) begin
        req = 1'b0;
        chk("busy_after_req", 32'(busy_a), 32'(1));
      end
      if (done_a && la == 0) la = i;
      if (done_b && lb == 0) lb = i;
    end
    chk("a_latency", la, la_exp);
    chk("b_latency", lb, lb_exp);
  endtask

  task automatic do_seed(input logic [7:0] sv);
    @(posedge clk); #1;
    seed_load  = 1'b1;
    seed_value = sv;
    @(posedge clk); #1;
    seed_load = 1'b0;
    ms_a = (sv == 8'hFF) ? 8'h55 : sv;
    ms_b = ms_a;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  logic [7:0] fr_exp [3];
  logic [7:0] b2b_s;
  logic [3:0] b2b_v;
  logic       b2b_f;
  int         b2b_l;

  initial begin
    fr_exp = '{8'hAA, 8'h54, 8'hA8};
    rst = 1'b1; free_run = 1'b0; seed_load = 1'b0; seed_value = 8'h00;
    req = 1'b0; limit = 4'd0;

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_state_a", 32'(lfsr_a), 32'h55);
    chk("rst_state_b", 32'(lfsr_b), 32'h55);
    chk("rst_busy", 32'(busy_a), 32'(0));
    chk("rst_done", 32'(done_a), 32'(0));
    chk("rst_value", 32'(value_a), 32'(0));
    chk("rst_fallback", 32'(fallback_a), 32'(0));

    // Free run for three cycles
    free_run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("free_run_state", 32'(lfsr_a), 32'(fr_exp[i]));
    end
    free_run = 1'b0;

    // Full-range draw from reset
    do_reset();
    do_draw(4'd0);
    chk("full_value", 32'(value_a), 32'h5);
    chk("full_state", 32'(lfsr_a), 32'hAA);

    // Fallback after two rejections
    do_draw(4'd3);
    chk("fb_value", 32'(value_a), 32'h0);
    chk("fb_flag", 32'(fallback_a), 32'(1));
    chk("fb_state", 32'(lfsr_a), 32'hA8);

    // Lock-up guard on seed load, then accept on first try
    do_seed(8'hFF);
    @(negedge clk);
    chk("lockup_state_a", 32'(lfsr_a), 32'h55);
    chk("lockup_state_b", 32'(lfsr_b), 32'h55);
    do_draw(4'd6);
    chk("accept6_value", 32'(value_b), 32'h5);
    chk("accept6_fallback", 32'(fallback_b), 32'(0));

    // Random limits, biased toward small ones to force rejections
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) do_draw(4'($urandom_range(1, 4)));
      else            do_draw(4'($urandom_range(0, 15)));
    end

    // Abort: seed_load in the first DRAW cycle
    @(posedge clk); #1;
    req   = 1'b1;
    limit = 4'd0;
    @(posedge clk); #1;
    chk("abort_busy_in_draw", 32'(busy_a), 32'(1));
    req        = 1'b0;
    seed_load  = 1'b1;
    seed_value = 8'h33;
    @(posedge clk); #1;
    seed_load = 1'b0;
    ms_a = 8'h33;
    ms_b = 8'h33;
    @(negedge clk);
    chk("abort_busy", 32'(busy_a), 32'(0));
    chk("abort_state_a", 32'(lfsr_a), 32'h33);
    chk("abort_state_b", 32'(lfsr_b), 32'h33);
    chk("abort_value_held", 32'(value_a), 32'(last_va));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done_a), 32'(0));
    end

    // Back-to-back: req held high, limit 0 -> done every 2 cycles
    for (int k = 0; k < 4; k++) begin
      draw_model(ms_a, 4'd0, 2, b2b_s, b2b_v, b2b_f, b2b_l);
      exp_qa.push_back({b2b_f, b2b_v, b2b_s});
      ms_a = b2b_s;
      draw_model(ms_b, 4'd0, 8, b2b_s, b2b_v, b2b_f, b2b_l);
      exp_qb.push_back({b2b_f, b2b_v, b2b_s});
      ms_b = b2b_s;
    end
    @(posedge clk); #1;
    req   = 1'b1;
    limit = 4'd0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("b2b_done", 32'(done_a), 32'(i % 2 == 0));
      chk("b2b_busy", 32'(busy_a), 32'(i % 2 == 1));
    end
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_idle_after", 32'(busy_a), 32'(0));

    // Everything expected must have been seen
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("qa_empty", 32'(exp_qa.size()), 32'(0));
    chk("qb_empty", 32'(exp_qb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
